// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared opcodes, FSM states and LUT reset contents for branch_ctrl
package branch_ctrl_pkg;

  localparam int DEF_IW        = 9;
  localparam int DEF_DW        = 8;
  localparam int DEF_LUT_DEPTH = 16;
  localparam int DEF_CW        = 16;

  localparam logic [3:0] OP_CMP  = 4'h1;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_BLT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // Forward offsets 2..9 in the low half, backward offsets -2..-9 in the high half.
  // The caller truncates the result to its data width.
  function automatic int lut_reset_val(input int i);
    if (i < 8) begin
      return i + 2;
    end else begin
      return 6 - i;
    end
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - fetch-stage branch/halt interface between control and program counter
interface branch_ctrl_if
  import branch_ctrl_pkg::*;
#(
  parameter int IW = DEF_IW,
  parameter int DW = DEF_DW
);

  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          branchsig;
  logic          branchtype;
  logic [DW-1:0] branch_out;
  logic          zero;
  logic          negative;
  logic          halt;

  // Control side: consumes the fetched instruction, produces branch/halt signals.
  modport master (
    input  instr,
    input  instr_valid,
    output branchsig,
    output branchtype,
    output branch_out,
    output zero,
    output negative,
    output halt
  );

  // Program-counter side.
  modport slave (
    output instr,
    output instr_valid,
    input  branchsig,
    input  branchtype,
    input  branch_out,
    input  zero,
    input  negative,
    input  halt
  );

endinterface

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - branch-offset register file, synchronous write, combinational read
module branch_lut
  import branch_ctrl_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_LUT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Reset reloads the default offsets and wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DW'(lut_reset_val(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-write contents; no write-through bypass.
  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - instruction decode, compare flags, halt FSM and perf counters for fetch
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int IW        = DEF_IW,
  parameter int DW        = DEF_DW,
  parameter int LUT_DEPTH = DEF_LUT_DEPTH,
  parameter int CW        = DEF_CW
) (
  input  logic               clk,
  input  logic               reset,
  branch_ctrl_if.master      fetch,
  input  logic [DW-1:0]      alu_a,
  input  logic [DW-1:0]      alu_b,
  input  logic               start,
  input  logic               lut_we,
  input  logic [3:0]         lut_addr,
  input  logic [DW-1:0]      lut_wdata,
  output logic [CW-1:0]      retired_cnt,
  output logic [CW-1:0]      taken_cnt
);

  state_t        state;
  state_t        state_next;
  logic [3:0]    op;
  logic [3:0]    idx;
  logic          unused_bits;
  logic          eq_f;
  logic          lt_f;
  logic          run_valid;
  logic          is_branch;
  logic          is_bne;
  logic          taken;
  logic          halt_int;
  logic [DW-1:0] lut_rdata;

  assign op          = fetch.instr[IW-1 -: 4];
  assign idx         = fetch.instr[3:0];
  assign unused_bits = ^fetch.instr[IW-5:4];

  assign run_valid = fetch.instr_valid && (state == RUN);
  assign is_bne    = (op == OP_BNE);
  assign is_branch = run_valid && (is_bne || (op == OP_BLT));
  assign taken     = is_branch && ((!is_bne && lt_f) || (is_bne && !eq_f));

  branch_lut #(
    .DW    (DW),
    .DEPTH (LUT_DEPTH)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_addr),
    .wdata (lut_wdata),
    .raddr (idx),
    .rdata (lut_rdata)
  );

  // Halt/resume state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and halt; halt asserts in the decode cycle so the PC holds on the HALT address.
  always_comb begin
    state_next = state;
    halt_int   = 1'b0;
    case (state)
      RUN: begin
        if (fetch.instr_valid && (op == OP_HALT)) begin
          state_next = HALTED;
          halt_int   = 1'b1;
        end
      end
      HALTED: begin
        halt_int = 1'b1;
        if (start) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Compare flags, updated only by a CMP executed in RUN; consumed by later branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      eq_f <= 1'b1;
      lt_f <= 1'b0;
    end else if (run_valid && (op == OP_CMP)) begin
      eq_f <= (alu_a == alu_b);
      lt_f <= ($signed(alu_a) < $signed(alu_b));
    end
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      taken_cnt   <= '0;
    end else begin
      if (run_valid && (op != OP_HALT)) begin
        retired_cnt <= retired_cnt + 1'b1;
      end
      if (taken) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

  // Fetch-side outputs; flags are inverted to match the PC's branch-taken sense.
  always_comb begin
    fetch.branchsig  = is_branch;
    fetch.branchtype = is_branch && is_bne;
    fetch.branch_out = is_branch ? lut_rdata : '0;
    fetch.zero       = ~eq_f;
    fetch.negative   = ~lt_f;
    fetch.halt       = halt_int;
  end

endmodule
